// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// Upper-case signal names match the register-file and HI/LO naming used by the pipeline.
interface mult_div_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  op;
    logic        start;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        stall_req;

    modport master (output A, B, op, start, input HI, LO, busy, stall_req);
    modport slave  (input A, B, op, start, output HI, LO, busy, stall_req);
endinterface

// File: rtl/mult_div_unit.sv
// MIPS mult/multu/div/divu/mthi/mtlo unit with fixed multi-cycle latency into HI/LO.
// The result is computed at issue and held in pending registers until the countdown ends.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [31:0] a, b;
    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, mag_b_safe, b_safe;
    logic [31:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;
    logic        div_by_zero, issue_md;

    assign a = bus.A;
    assign b = bus.B;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign div_by_zero = (b == 32'd0);
    assign b_safe      = div_by_zero ? 32'd1 : b;
    assign mag_a       = a[31] ? (32'd0 - a) : a;
    assign mag_b       = b[31] ? (32'd0 - b) : b;
    assign mag_b_safe  = div_by_zero ? 32'd1 : mag_b;
    assign q_mag       = mag_a / mag_b_safe;
    assign r_mag       = mag_a % mag_b_safe;
    assign quo_s       = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    assign rem_s       = a[31] ? (32'd0 - r_mag) : r_mag;
    assign quo_u       = a / b_safe;
    assign rem_u       = a % b_safe;

    assign issue_md = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
                        OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
                        // Divide by zero commits the current HI/LO back, leaving them unchanged.
                        OP_DIV:   {pend_hi_d, pend_lo_d} = div_by_zero ? {hi_q, lo_q} : {rem_s, quo_s};
                        OP_DIVU:  {pend_hi_d, pend_lo_d} = div_by_zero ? {hi_q, lo_q} : {rem_u, quo_u};
                        OP_MTHI:  hi_d = a;
                        OP_MTLO:  lo_d = a;
                        default:  ;
                    endcase
                    if (issue_md) begin
                        cnt_d   = (bus.op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.busy      = busy_q;
    assign bus.stall_req = busy_q | issue_md;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares on every completion the DUT presents.
module tb_mult_div_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if bus();

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: architectural MIPS semantics in plain integer arithmetic.
    task automatic model_issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        int              sa, sb, q, r;
        exp_t            e;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            3'd1: begin ps = longint'(sa) * longint'(sb); {m_hi, m_lo} = ps; e.name = "mult"; end
            3'd2: begin pu = 64'(a) * 64'(b); {m_hi, m_lo} = pu; e.name = "multu"; end
            3'd3: begin
                e.name = "div";
                if (b != 0) begin
                    if (a == 32'h8000_0000 && sb == -1) begin q = sa; r = 0; end
                    else begin q = sa / sb; r = sa % sb; end
                    m_lo = q; m_hi = r;
                end
            end
            3'd4: begin
                e.name = "divu";
                if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            end
            3'd5: begin m_hi = a; e.name = "mthi"; end
            3'd6: begin m_lo = a; e.name = "mtlo"; end
            default: return;
        endcase
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.len = (o <= 3'd2) ? MULT_N : (o <= 3'd4) ? DIV_N : 0;
        sb_q.push_back(e);
    endtask

    // Monitor: edge-side sampling of issue/reset, negedge-side comparison.
    logic mv_seen = 1'b0, rst_seen = 1'b0, prev_busy = 1'b0;
    int   run_len = 0;

    always @(posedge clk) begin
        mv_seen  = bus.start && !bus.busy && (bus.op == 3'd5 || bus.op == 3'd6) && !reset;
        rst_seen = reset;
    end

    task automatic pop_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: HI=%h LO=%h with no pending expectation", bus.HI, bus.LO);
        end else begin
            e = sb_q.pop_front();
            check32({e.name, "_hi"}, bus.HI, e.hi);
            check32({e.name, "_lo"}, bus.LO, e.lo);
            check_int({e.name, "_busy_len"}, run_len, e.len);
        end
        run_len = 0;
    endtask

    always @(negedge clk) begin
        if (rst_seen) run_len = 0;
        else if (mv_seen) pop_compare();
        else if (prev_busy && !bus.busy) pop_compare();
        if (bus.busy) run_len++;
        prev_busy = bus.busy;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit accept);
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        if (accept) model_issue(o, a, b);
        #1;
        if (o >= 3'd1 && o <= 3'd4) check_int("stall_req_issue", int'(bus.stall_req), 1);
        else if (accept) check_int("stall_req_idle", int'(bus.stall_req), 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        @(negedge clk);
        if (accept && o >= 3'd1 && o <= 3'd4) check_int("busy_after_issue", int'(bus.busy), 1);
    endtask

    // Operand and op lines are scrambled while busy; the unit must ignore them.
    task automatic wait_idle();
        int k = 0;
        while (bus.busy === 1'b1 && k < 40) begin
            bus.A  = $urandom;
            bus.B  = $urandom;
            bus.op = 3'($urandom_range(0, 7));
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL busy_timeout: busy=%b after %0d cycles, expected 0", bus.busy, k);
        end
        bus.op = 3'd0;
    endtask

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        m_hi      = '0;
        m_lo      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check32("reset_hi", bus.HI, 32'd0);
        check32("reset_lo", bus.LO, 32'd0);
        check_int("reset_busy", int'(bus.busy), 0);
        check_int("reset_stall", int'(bus.stall_req), 0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_idle();
        check32("plan_mult_hi", bus.HI, 32'hFFFF_FFFF);
        check32("plan_mult_lo", bus.LO, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        check32("plan_multu_hi", bus.HI, 32'hFFFF_FFFE);
        check32("plan_multu_lo", bus.LO, 32'h0000_0001);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        check32("plan_div_lo", bus.LO, 32'hFFFF_FFFD);
        check32("plan_div_hi", bus.HI, 32'hFFFF_FFFF);
        issue(3'd4, 32'd7, 32'd0, 1'b1);
        wait_idle();
        check32("plan_divu0_hi", bus.HI, 32'hFFFF_FFFF);
        check32("plan_divu0_lo", bus.LO, 32'hFFFF_FFFD);

        issue(3'd5, 32'h1234_5678, 32'd0, 1'b1);
        issue(3'd6, 32'hCAFE_BABE, 32'd0, 1'b1);
        check32("plan_mthi", bus.HI, 32'h1234_5678);
        check32("plan_mtlo", bus.LO, 32'hCAFE_BABE);

        // Issues during RUN must be dropped without disturbing the running op.
        issue(3'd1, 32'd1000, 32'hFFFF_FFFD, 1'b1);
        @(negedge clk);
        issue(3'd2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        issue(3'd5, 32'h5555_AAAA, 32'd0, 1'b0);
        wait_idle();
        check32("ignored_hi", bus.HI, 32'hFFFF_FFFF);
        check32("ignored_lo", bus.LO, 32'hFFFF_F448);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        check32("div_ovf_lo", bus.LO, 32'h8000_0000);
        check32("div_ovf_hi", bus.HI, 32'h0000_0000);

        // Reset during the fourth busy cycle of a divide aborts it.
        issue(3'd3, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        check_int("abort_busy", int'(bus.busy), 0);
        check32("abort_hi", bus.HI, 32'd0);
        check32("abort_lo", bus.LO, 32'd0);
        repeat (15) @(negedge clk);
        check32("abort_no_commit_hi", bus.HI, 32'd0);
        check32("abort_no_commit_lo", bus.LO, 32'd0);

        issue(3'd1, 32'd123, 32'd456, 1'b1);
        wait_idle();
        issue(3'd1, 32'hFFFF_FF00, 32'h0000_0100, 1'b1);
        wait_idle();
        check32("b2b_hi", bus.HI, 32'hFFFF_FFFF);
        check32("b2b_lo", bus.LO, 32'hFFFF_0000);

        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 20)) - 32'd10;
            if ($urandom_range(0, 3) == 0 && b != 0) b = 32'($urandom_range(1, 9));
            issue(o, a, b, 1'b1);
            wait_idle();
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check_int("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the EX stage, alongside the ALU. It takes the same two 32-bit register operands and executes MIPS mult, multu, div, divu, mthi and mtlo with fixed multi-cycle latency into architectural HI/LO registers. It raises a stall request so hazard logic holds the pipeline while an operation is outstanding.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- A  in  32  rs operand.
- B  in  32  rt operand.
- op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
- start  in  1  issue op this cycle; ignored when op is 0 or 7.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.
- busy  out  1  registered; an operation is in flight.
- stall_req  out  1  combinational; equals busy, OR start with op in 1..4.

## Operation

- State machine: IDLE, RUN.
- IDLE, start with op 1..4:
  - Latch the full result into pending registers.
  - mult/multu: {pend_hi, pend_lo} = 64-bit product, signed/unsigned respectively.
  - div/divu: pend_lo = quotient, pend_hi = remainder. Truncate toward zero; the remainder takes the sign of the dividend for div.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1.
- IDLE, start with op 5: HI <= A at this edge; LO unchanged. Op 6: LO <= A. No busy.
- RUN: counter decrements each cycle. When it reaches 1: HI <= pend_hi, LO <= pend_lo, busy <= 0, go to IDLE on the same edge.
- start while busy (any op, including mthi/mtlo) is ignored entirely. Hazard logic never issues this, but the block must stay unaffected.
- Divide by zero (B=0, div or divu): runs the full DIV_CYCLES with busy; HI and LO are left unchanged at completion.
- div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- Operands are sampled only at the start edge. Changes to A or B during RUN have no effect.
- HI/LO are readable combinationally at all times. During RUN they hold the values from before the operation.

## Timing

- Reset values: HI=0, LO=0, busy=0, state=IDLE, counter=0, pending registers=0. stall_req=0 when start=0.
- Reset asserted during RUN aborts the operation at that edge. HI/LO go to 0, and no commit occurs afterwards.
- start sampled at edge E0. busy=1 in cycles 1..N, where N is MULT_CYCLES or DIV_CYCLES. HI/LO update at the edge ending cycle N and become visible in cycle N+1, where busy=0.
- A new start is accepted in cycle N+1, which gives back-to-back issue.
- stall_req is high in cycle 0 (combinational from start) and cycles 1..N.
- mthi/mtlo: 1-cycle write, visible the cycle after the start edge.

## Test plan

- Reset, then mult A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall_req high in the issue cycle.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
- mthi A=0x12345678, then next cycle mtlo A=0xCAFEBABE -> HI=0x12345678, LO=0xCAFEBABE; busy never asserts. A second mult issued in cycle 3 of a running mult is ignored, and the first result is committed unchanged.
- Start div, assert reset in cycle 4 -> busy=0 and HI=LO=0 next cycle; no later commit. A back-to-back mult issued in cycle N+1 after a mult completes -> accepted, second result correct.
